hpc_bus_master: RTL and testbench



---
 rtl/hpc_bus_pkg.sv | 21 ++
 rtl/hpc_bus_master.sv | 120 ++++++++++++
 tb/tb_hpc_bus_master.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hpc_bus_pkg.sv
// Shared definitions for the hpc bus master: FSM states, control-slave register map
// and control-word bit positions.
package hpc_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [4:0] ADDR_CTRL      = 5'h00;
  localparam logic [4:0] ADDR_DATA_CTR  = 5'h04;
  localparam logic [4:0] ADDR_EVENT_CTR = 5'h08;
  localparam logic [4:0] ADDR_VERSION   = 5'h0C;

  localparam int CTRL_RESET_BIT  = 0;
  localparam int CTRL_ENABLE_BIT = 1;
  localparam int CTRL_FREEZE_BIT = 2;

endpackage

// File: rtl/hpc_bus_master.sv
// Single-outstanding Avalon-MM master: one host command in, one Avalon transfer,
// one response out. Current FSM state is exported on the state port for debug.
module hpc_bus_master
  import hpc_bus_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [WIDTH-1:0]  cmd_writedata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_is_read,
  output logic              resp_err,
  output logic [WIDTH-1:0]  resp_data,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  output logic              master_write,
  output logic [WIDTH-1:0]  master_writedata,
  input  logic              master_waitrequest,
  input  logic [WIDTH-1:0]  master_readdata,
  output logic [WIDTH-1:0]  txn_count,
  output state_t            state
);

  localparam logic [1:0]  LAT_LOAD    = 2'(READ_LATENCY - 1);
  localparam logic [31:0] STALL_LIMIT = 32'(TIMEOUT - 1);

  logic        write_q;
  logic [1:0]  lat_cnt;
  logic [31:0] stall_cnt;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the producer holds valid and payload stable until that edge.
  assign cmd_ready = (state == IDLE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      write_q          <= 1'b0;
      lat_cnt          <= '0;
      stall_cnt        <= '0;
      master_read      <= 1'b0;
      master_write     <= 1'b0;
      master_address   <= '0;
      master_writedata <= '0;
      resp_valid       <= 1'b0;
      resp_err         <= 1'b0;
      resp_is_read     <= 1'b0;
      resp_data        <= '0;
      txn_count        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            write_q          <= cmd_write;
            master_address   <= cmd_address;
            master_writedata <= cmd_writedata;
            master_write     <= cmd_write;
            master_read      <= !cmd_write;
            stall_cnt        <= '0;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          if (!master_waitrequest) begin
            master_read  <= 1'b0;
            master_write <= 1'b0;
            resp_is_read <= !write_q;
            resp_err     <= 1'b0;
            if (write_q) begin
              resp_data  <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              lat_cnt <= LAT_LOAD;
              state   <= RDWAIT;
            end
          end else if (TIMEOUT != 0 && stall_cnt == STALL_LIMIT) begin
            // This is the TIMEOUT-th stalled cycle: abandon the transfer.
            master_read  <= 1'b0;
            master_write <= 1'b0;
            resp_is_read <= !write_q;
            resp_err     <= 1'b1;
            resp_data    <= '0;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end else begin
            stall_cnt <= stall_cnt + 32'd1;
          end
        end
        RDWAIT: begin
          if (lat_cnt == 2'd0) begin
            resp_data  <= master_readdata;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            txn_count  <= txn_count + WIDTH'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hpc_bus_master.sv
// Directed bench for hpc_bus_master: vector table run cycle by cycle on a latency-1
// instance, plus reset-during-read sequence on a latency-3 instance.
module tb_hpc_bus_master;
  import hpc_bus_pkg::*;

  localparam int W   = 32;
  localparam int AW  = 5;
  localparam int TMO = 8;
  localparam logic [W-1:0] JUNK = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_address = '0;
  logic [W-1:0]  cmd_writedata = '0;
  logic          resp_ready = 1'b0;
  logic          master_waitrequest = 1'b0;
  logic [W-1:0]  master_readdata = '0;

  logic          cmd_ready, resp_valid, resp_is_read, resp_err, master_read, master_write;
  logic [W-1:0]  resp_data, master_writedata, txn_count;
  logic [AW-1:0] master_address;
  state_t        state;

  logic          d3_cmd_ready, d3_resp_valid, d3_resp_is_read, d3_resp_err;
  logic          d3_master_read, d3_master_write;
  logic [W-1:0]  d3_resp_data, d3_master_writedata, d3_txn_count;
  logic [AW-1:0] d3_master_address;
  state_t        d3_state;

  hpc_bus_master #(.WIDTH(W), .ADDR_W(AW), .READ_LATENCY(1), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_is_read(resp_is_read),
    .resp_err(resp_err), .resp_data(resp_data),
    .master_address(master_address), .master_read(master_read), .master_write(master_write),
    .master_writedata(master_writedata), .master_waitrequest(master_waitrequest),
    .master_readdata(master_readdata), .txn_count(txn_count), .state(state)
  );

  hpc_bus_master #(.WIDTH(W), .ADDR_W(AW), .READ_LATENCY(3), .TIMEOUT(TMO)) dut3 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(d3_cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_writedata(cmd_writedata),
    .resp_valid(d3_resp_valid), .resp_ready(resp_ready), .resp_is_read(d3_resp_is_read),
    .resp_err(d3_resp_err), .resp_data(d3_resp_data),
    .master_address(d3_master_address), .master_read(d3_master_read),
    .master_write(d3_master_write), .master_writedata(d3_master_writedata),
    .master_waitrequest(master_waitrequest), .master_readdata(master_readdata),
    .txn_count(d3_txn_count), .state(d3_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_count = '0;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    int            stall;
    int            ready_delay;
    logic [W-1:0]  rdata;
    logic          exp_err;
    logic [W-1:0]  exp_data;
    int            exp_resp_cycle;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle 0 is the command handshake; every output is sampled on the falling edge.
  task automatic run_vec(input vec_t v, input logic [W-1:0] base_count);
    bit           tmo;
    int           issue_end;
    int           hs;
    int           data_cyc;
    bit           in_resp;
    logic [W-1:0] popped;
    tmo       = (v.stall >= TMO);
    issue_end = tmo ? TMO : v.stall + 1;
    hs        = v.exp_resp_cycle + v.ready_delay;
    data_cyc  = v.stall + 2;
    @(posedge clk); #1;
    cmd_valid          = 1'b1;
    cmd_write          = v.write;
    cmd_address        = v.addr;
    cmd_writedata      = v.wdata;
    resp_ready         = 1'b0;
    master_waitrequest = 1'b0;
    master_readdata    = JUNK;
    exp_q.push_back(v.exp_data);
    @(negedge clk);
    check("cmd_ready_c0", cmd_ready, 1'b1);
    for (int cyc = 1; cyc <= hs + 1; cyc++) begin
      @(posedge clk); #1;
      cmd_valid          = 1'b0;
      master_waitrequest = (cyc <= v.stall);
      master_readdata    = (!v.write && !tmo && cyc == data_cyc) ? v.rdata : JUNK;
      resp_ready         = (cyc >= hs);
      @(negedge clk);
      in_resp = (cyc >= v.exp_resp_cycle) && (cyc <= hs);
      check("master_read", master_read, !v.write && cyc <= issue_end);
      check("master_write", master_write, v.write && cyc <= issue_end);
      if (cyc <= issue_end) begin
        check("master_address", master_address, v.addr);
        if (v.write) check("master_writedata", master_writedata, v.wdata);
      end
      check("resp_valid", resp_valid, in_resp);
      if (in_resp) begin
        check("resp_is_read", resp_is_read, !v.write);
        check("resp_err", resp_err, v.exp_err);
        check("resp_data", resp_data, v.exp_data);
      end
      if (cyc == hs) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
          popped = exp_q.pop_front();
          check("sb_resp_data", resp_data, popped);
        end
      end
      check("cmd_ready", cmd_ready, cyc > hs);
      check("txn_count", txn_count, base_count + W'(cyc > hs));
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, ADDR_CTRL,      32'h0000_0002, 0,  0, 32'h0,         1'b0, 32'h0,         2};
    vecs[1] = '{1'b0, ADDR_VERSION,   32'h0,         0,  0, 32'd20,        1'b0, 32'd20,        3};
    vecs[2] = '{1'b0, ADDR_DATA_CTR,  32'h0,         3,  0, 32'h0000_1234, 1'b0, 32'h0000_1234, 6};
    vecs[3] = '{1'b0, ADDR_EVENT_CTR, 32'h0,         30, 0, 32'h1111_1111, 1'b1, 32'h0,         9};
    vecs[4] = '{1'b1, ADDR_CTRL,      32'h0000_0005, 0,  5, 32'h0,         1'b0, 32'h0,         2};
    vecs[5] = '{1'b0, ADDR_DATA_CTR,  32'h0,         1,  2, 32'hA5A5_0F0F, 1'b0, 32'hA5A5_0F0F, 4};
    vecs[6] = '{1'b1, ADDR_VERSION,   32'h0000_00FF, 8,  0, 32'h0,         1'b1, 32'h0,         9};
    vecs[7] = '{1'b1, ADDR_EVENT_CTR, 32'h0000_CAFE, 7,  1, 32'h0,         1'b0, 32'h0,         9};
    vecs[8] = '{1'b0, ADDR_EVENT_CTR, 32'h0,         7,  0, 32'h0000_0042, 1'b0, 32'h0000_0042, 10};

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_master_read", master_read, 1'b0);
    check("rst_master_write", master_write, 1'b0);
    check("rst_master_address", master_address, '0);
    check("rst_master_writedata", master_writedata, '0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_err", resp_err, 1'b0);
    check("rst_resp_is_read", resp_is_read, 1'b0);
    check("rst_resp_data", resp_data, '0);
    check("rst_txn_count", txn_count, '0);
    check("rst_state", state, IDLE);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1'b1);

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], exp_count);
      exp_count = exp_count + W'(1);
    end

    // Reset while the latency-3 instance waits for read data.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    cmd_valid          = 1'b1;
    cmd_write          = 1'b0;
    cmd_address        = ADDR_DATA_CTR;
    resp_ready         = 1'b1;
    master_waitrequest = 1'b0;
    master_readdata    = JUNK;
    @(negedge clk);
    check("l3_cmd_ready_c0", d3_cmd_ready, 1'b1);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (cyc == 3) reset = 1'b1;
      @(negedge clk);
      check("l3_master_read", d3_master_read, cyc == 1);
      if (cyc >= 2) check("l3_state_rdwait", d3_state, RDWAIT);
    end
    @(posedge clk); #1;
    reset           = 1'b0;
    master_readdata = 32'h0000_0777;
    @(negedge clk);
    check("l3_cmd_ready_after_rst", d3_cmd_ready, 1'b1);
    check("l3_master_read_after_rst", d3_master_read, 1'b0);
    check("l3_resp_valid_after_rst", d3_resp_valid, 1'b0);
    check("l3_state_after_rst", d3_state, IDLE);
    for (int cyc = 5; cyc <= 7; cyc++) begin
      @(posedge clk); #1;
      master_readdata = JUNK;
      @(negedge clk);
      check("l3_no_resp", d3_resp_valid, 1'b0);
      check("l3_no_capture", d3_resp_data, '0);
      check("l3_txn_count_zero", d3_txn_count, '0);
    end

    // Fresh read after the reset.
    @(posedge clk); #1;
    cmd_valid   = 1'b1;
    cmd_write   = 1'b0;
    cmd_address = ADDR_VERSION;
    @(negedge clk);
    check("l3_fresh_cmd_ready", d3_cmd_ready, 1'b1);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk); #1;
      cmd_valid       = 1'b0;
      master_readdata = (cyc == 4) ? 32'h0000_0BEE : JUNK;
      @(negedge clk);
      check("l3_fresh_master_read", d3_master_read, cyc == 1);
      if (cyc == 1) check("l3_fresh_address", d3_master_address, ADDR_VERSION);
      check("l3_fresh_resp_valid", d3_resp_valid, cyc == 5);
      if (cyc == 5) begin
        check("l3_fresh_resp_data", d3_resp_data, 32'h0000_0BEE);
        check("l3_fresh_is_read", d3_resp_is_read, 1'b1);
        check("l3_fresh_err", d3_resp_err, 1'b0);
      end
      if (cyc == 6) begin
        check("l3_fresh_txn_count", d3_txn_count, 32'd1);
        check("l3_fresh_cmd_ready_end", d3_cmd_ready, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
